// File: rtl/tensor_block_param.sv
// Parameterised multi-lane dot-product accumulator with shared weight bank and group FSM.
// Optional saturating accumulation under macro TENSOR_ACC_SAT_EN (wraps modulo 2^ACCW otherwise).
// state | meaning
// IDLE  | no accumulation group open
// OPEN  | group open, samples add into acc
module tensor_block_param #(
    parameter int LANES = 10,
    parameter int DW    = 8,
    parameter int NDOT  = 3,
    parameter int ACCW  = 32,
    parameter int OUTW  = 25
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    input  logic [LANES*DW-1:0]    data_in,
    input  logic                   acc_first,
    input  logic                   acc_last,
    input  logic                   signed_mode,
    input  logic                   weight_load,
    input  logic [LANES*DW-1:0]    weight_in,
    input  logic                   acc_in_sel,
    input  logic [NDOT*ACCW-1:0]   acc_in,
    output logic                   out_valid,
    output logic [NDOT*OUTW-1:0]   out,
    output logic [NDOT*ACCW-1:0]   acc_out,
    output logic                   busy
);
    localparam int T  = $clog2(LANES);
    localparam int P  = 1 << T;
    localparam int TW = 2*DW + 2 + T;
    localparam int NS = T + 2;
`ifdef TENSOR_ACC_SAT_EN
    localparam int SN = NS;
`else
    localparam int SN = 1;
`endif

    typedef enum logic {IDLE, OPEN} state_t;

    state_t                 state, state_nx;
    logic [LANES*DW-1:0]    w     [NDOT];
    logic [LANES*DW-1:0]    ws_q  [NDOT];
    logic [LANES*DW-1:0]    x_q;
    logic [NS-1:0]          v_p, first_p, last_p, sel_p;
    logic [SN-1:0]          sgn_p;
    logic signed [TW-1:0]   lvl   [T+1][NDOT][P];
    logic [ACCW-1:0]        dot   [NDOT];
    logic [ACCW-1:0]        acc   [NDOT];
    logic [ACCW-1:0]        acc_nx[NDOT];
    logic [ACCW-1:0]        base;
    logic                   ov_nx;
    logic                   start;

    // Operands widened to the full tree width so one multiplier covers both modes.
    function automatic logic signed [TW-1:0] lane_mul(input logic [DW-1:0] a,
                                                     input logic [DW-1:0] b,
                                                     input logic sm);
        logic signed [TW-1:0] pa, pb;
        pa = {{(TW-DW){sm & a[DW-1]}}, a};
        pb = {{(TW-DW){sm & b[DW-1]}}, b};
        return pa * pb;
    endfunction

`ifdef TENSOR_ACC_SAT_EN
    function automatic logic [ACCW-1:0] sat_add(input logic [ACCW-1:0] a,
                                                input logic [ACCW-1:0] b,
                                                input logic sm);
        logic [ACCW:0] s;
        if (sm) begin
            s = {a[ACCW-1], a} + {b[ACCW-1], b};
            if (s[ACCW] != s[ACCW-1])
                return s[ACCW] ? {1'b1, {(ACCW-1){1'b0}}} : {1'b0, {(ACCW-1){1'b1}}};
        end else begin
            s = {1'b0, a} + {1'b0, b};
            if (s[ACCW]) return '1;
        end
        return s[ACCW-1:0];
    endfunction
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NDOT; i++) w[i] <= '0;
        end else if (weight_load) begin
            w[0] <= weight_in;
            for (int i = 1; i < NDOT; i++) w[i] <= w[i-1];
        end
    end

    // Control bits travel alongside the datapath; only v_p needs clearing.
    always_ff @(posedge clk) begin
        if (reset) v_p <= '0;
        else       v_p <= {v_p[NS-2:0], in_valid};
        first_p  <= {first_p[NS-2:0], acc_first};
        last_p   <= {last_p[NS-2:0], acc_last};
        sel_p    <= {sel_p[NS-2:0], acc_in_sel};
        sgn_p[0] <= signed_mode;
        for (int i = 1; i < SN; i++) sgn_p[i] <= sgn_p[i-1];
        if (in_valid) begin
            x_q  <= data_in;
            ws_q <= w;
        end
    end

    always_ff @(posedge clk) begin
        for (int k = 0; k < NDOT; k++) begin
            for (int i = 0; i < LANES; i++)
                lvl[0][k][i] <= lane_mul(x_q[i*DW +: DW], ws_q[k][i*DW +: DW], sgn_p[0]);
            for (int i = LANES; i < P; i++)
                lvl[0][k][i] <= '0;
        end
        for (int s = 1; s <= T; s++) begin
            for (int k = 0; k < NDOT; k++) begin
                for (int i = 0; i < (P >> s); i++)
                    lvl[s][k][i] <= lvl[s-1][k][2*i] + lvl[s-1][k][2*i+1];
                for (int i = (P >> s); i < P; i++)
                    lvl[s][k][i] <= '0;
            end
        end
    end

    always_comb begin
        for (int k = 0; k < NDOT; k++)
            dot[k] = {{(ACCW-TW){lvl[T][k][0][TW-1]}}, lvl[T][k][0]};
    end

    always_comb begin
        state_nx = state;
        acc_nx   = acc;
        ov_nx    = 1'b0;
        start    = 1'b0;
        base     = '0;
        if (v_p[NS-1]) begin
            start = first_p[NS-1] || (state == IDLE);
            for (int k = 0; k < NDOT; k++) begin
                if (!start)                             base = acc[k];
                else if (first_p[NS-1] && sel_p[NS-1])  base = acc_in[k*ACCW +: ACCW];
                else                                    base = '0;
`ifdef TENSOR_ACC_SAT_EN
                acc_nx[k] = sat_add(base, dot[k], sgn_p[SN-1]);
`else
                acc_nx[k] = base + dot[k];
`endif
            end
            ov_nx    = last_p[NS-1];
            state_nx = last_p[NS-1] ? IDLE : OPEN;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            for (int k = 0; k < NDOT; k++) acc[k] <= '0;
        end else begin
            state     <= state_nx;
            out_valid <= ov_nx;
            acc       <= acc_nx;
        end
    end

    always_comb begin
        out     = '0;
        acc_out = '0;
        for (int k = 0; k < NDOT; k++) begin
            out[k*OUTW +: OUTW]     = acc[k][ACCW-1 -: OUTW];
            acc_out[k*ACCW +: ACCW] = acc[k];
        end
    end

    assign busy = (|v_p) || (state == OPEN);

endmodule

// File: tb/tb_tensor_block_param.sv
// Directed bench for tensor_block_param at default parameters: vector table plus corner sequences.
module tb_tensor_block_param;
    localparam int LANES = 10;
    localparam int DW    = 8;
    localparam int NDOT  = 3;
    localparam int ACCW  = 32;
    localparam int OUTW  = 25;

    logic                  clk = 1'b0;
    logic                  reset;
    logic                  in_valid;
    logic [LANES*DW-1:0]   data_in;
    logic                  acc_first, acc_last, signed_mode;
    logic                  weight_load;
    logic [LANES*DW-1:0]   weight_in;
    logic                  acc_in_sel;
    logic [NDOT*ACCW-1:0]  acc_in;
    logic                  out_valid;
    logic [NDOT*OUTW-1:0]  out;
    logic [NDOT*ACCW-1:0]  acc_out;
    logic                  busy;

    int total = 0;
    int bad   = 0;

    tensor_block_param #(.LANES(LANES), .DW(DW), .NDOT(NDOT), .ACCW(ACCW), .OUTW(OUTW)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .data_in(data_in),
        .acc_first(acc_first), .acc_last(acc_last), .signed_mode(signed_mode),
        .weight_load(weight_load), .weight_in(weight_in), .acc_in_sel(acc_in_sel),
        .acc_in(acc_in), .out_valid(out_valid), .out(out), .acc_out(acc_out), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        sm;
        logic [7:0]  d;
        logic [7:0]  wv;
        int          n;
        logic        sel;
        logic [31:0] seed;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[7];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1; in_valid = 1'b0; acc_first = 1'b0; acc_last = 1'b0;
        signed_mode = 1'b0; weight_load = 1'b0; data_in = '0; weight_in = '0;
        acc_in_sel = 1'b0; acc_in = '0;
        tick(); tick();
        reset = 1'b0;
    endtask

    task automatic load_w(input logic [7:0] v);
        weight_load = 1'b1;
        weight_in   = {LANES{v}};
        tick();
        weight_load = 1'b0;
    endtask

    task automatic send(input logic [7:0] d, input logic sm, input logic f, input logic l);
        in_valid = 1'b1; data_in = {LANES{d}}; signed_mode = sm;
        acc_first = f; acc_last = l;
        tick();
        in_valid = 1'b0; acc_first = 1'b0; acc_last = 1'b0;
    endtask

    task automatic wait_out(output int cyc);
        cyc = 1;
        while (!out_valid && cyc < 20) begin
            tick();
            cyc++;
        end
    endtask

    task automatic check_units(input string name, input logic [31:0] e0,
                               input logic [31:0] e1, input logic [31:0] e2);
        logic [31:0] e [3];
        e[0] = e0; e[1] = e1; e[2] = e2;
        for (int k = 0; k < NDOT; k++) begin
            check($sformatf("%s_acc%0d", name, k), 96'(acc_out[k*ACCW +: ACCW]), 96'(e[k]));
            check($sformatf("%s_out%0d", name, k), 96'(out[k*OUTW +: OUTW]), 96'(e[k][31:7]));
        end
    endtask

    initial begin
        int cyc;
        int pulses;
        logic [31:0] seen;

        vecs[0] = '{"uns_2x2",   1'b0, 8'h02, 8'h02, 1, 1'b0, 32'h0,        32'd40};
        vecs[1] = '{"sgn_m1x3",  1'b1, 8'hFF, 8'h03, 4, 1'b0, 32'h0,        32'hFFFFFF88};
        vecs[2] = '{"uns_ffx3",  1'b0, 8'hFF, 8'h03, 4, 1'b0, 32'h0,        32'd30600};
        vecs[3] = '{"seed_1000", 1'b0, 8'h02, 8'h02, 1, 1'b1, 32'd1000,     32'd1040};
`ifdef TENSOR_ACC_SAT_EN
        vecs[4] = '{"seed_wrap", 1'b0, 8'h02, 8'h02, 1, 1'b1, 32'hFFFFFFF0, 32'hFFFFFFFF};
`else
        vecs[4] = '{"seed_wrap", 1'b0, 8'h02, 8'h02, 1, 1'b1, 32'hFFFFFFF0, 32'h00000018};
`endif
        vecs[5] = '{"sgn_minsq", 1'b1, 8'h80, 8'h80, 1, 1'b0, 32'h0,        32'd163840};
        vecs[6] = '{"sgn_posng", 1'b1, 8'h7F, 8'hFE, 2, 1'b0, 32'h0,        32'hFFFFEC28};

        do_reset();
        check("rst_out_valid", 96'(out_valid), 96'(0));
        check("rst_busy",      96'(busy),      96'(0));
        check("rst_acc_out",   96'(acc_out),   96'(0));
        check("rst_out",       96'(out),       96'(0));

        foreach (vecs[v]) begin
            do_reset();
            acc_in_sel = vecs[v].sel;
            acc_in     = {NDOT{vecs[v].seed}};
            for (int i = 0; i < NDOT; i++) load_w(vecs[v].wv);
            for (int s = 0; s < vecs[v].n; s++)
                send(vecs[v].d, vecs[v].sm, s == 0, s == vecs[v].n - 1);
            wait_out(cyc);
            check({vecs[v].name, "_latency"}, 96'(cyc), 96'(7));
            check_units(vecs[v].name, vecs[v].exp, vecs[v].exp, vecs[v].exp);
            tick();
            check({vecs[v].name, "_pulse"}, 96'(out_valid), 96'(0));
        end

        // Distinct weights per unit, and a load concurrent with a sample.
        do_reset();
        load_w(8'd1); load_w(8'd2); load_w(8'd3);
        send(8'd1, 1'b0, 1'b1, 1'b1);
        wait_out(cyc);
        check_units("wbank", 32'd30, 32'd20, 32'd10);
        weight_load = 1'b1; weight_in = {LANES{8'd5}};
        send(8'd1, 1'b0, 1'b1, 1'b1);
        weight_load = 1'b0;
        wait_out(cyc);
        check_units("wconc_old", 32'd30, 32'd20, 32'd10);
        send(8'd1, 1'b0, 1'b1, 1'b1);
        wait_out(cyc);
        check_units("wconc_new", 32'd50, 32'd30, 32'd20);

        // Back-to-back single-sample groups.
        do_reset();
        for (int i = 0; i < NDOT; i++) load_w(8'd2);
        send(8'd2, 1'b0, 1'b1, 1'b1);
        check("busy_inflight", 96'(busy), 96'(1));
        send(8'd1, 1'b0, 1'b1, 1'b1);
        wait_out(cyc);
        check("b2b_lat", 96'(cyc), 96'(6));
        check("b2b_acc_a", 96'(acc_out[31:0]), 96'(40));
        tick();
        check("b2b_ov_b", 96'(out_valid), 96'(1));
        check("b2b_acc_b", 96'(acc_out[31:0]), 96'(20));
        tick();
        check("b2b_ov_end", 96'(out_valid), 96'(0));

        // Open group discarded by a new first.
        send(8'd2, 1'b0, 1'b1, 1'b0);
        send(8'd1, 1'b0, 1'b1, 1'b1);
        pulses = 0; seen = '0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (out_valid) begin pulses++; seen = acc_out[31:0]; end
        end
        check("discard_pulses", 96'(pulses), 96'(1));
        check("discard_acc",    96'(seen),   96'(20));
        check("idle_busy",      96'(busy),   96'(0));

        // Bubbles inside a group, then first=0 while idle.
        send(8'd2, 1'b0, 1'b1, 1'b0);
        tick(); tick(); tick();
        send(8'd2, 1'b0, 1'b0, 1'b1);
        wait_out(cyc);
        check("bubble_acc", 96'(acc_out[31:0]), 96'(80));
        tick();
        send(8'd1, 1'b0, 1'b0, 1'b1);
        wait_out(cyc);
        check("nofirst_lat", 96'(cyc), 96'(7));
        check("nofirst_acc", 96'(acc_out[31:0]), 96'(20));

        // Reset mid-flight.
        send(8'd2, 1'b0, 1'b1, 1'b1);
        tick(); tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("midrst_busy", 96'(busy),    96'(0));
        check("midrst_acc",  96'(acc_out), 96'(0));
        pulses = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (out_valid) pulses++;
        end
        check("midrst_pulses", 96'(pulses), 96'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
